// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: CH valid/ready input channels merged onto one
// registered valid/ready output carrying the data and the winning channel index.
interface rr_mux_reg_if #(
  parameter int N  = 32,
  parameter int CH = 4
);
  localparam int SW = $clog2(CH);

  logic [CH-1:0]   in_valid;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_ready;
  logic            out_valid;
  logic [N-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_reg.sv
// Round-robin arbitrating N-bit multiplexer over CH channels with one registered
// output stage; in_ready is combinational, all outputs on the consumer side are flops.
module rr_mux_reg #(
  parameter int N  = 32,
  parameter int CH = 4
) (
  input  logic          clk,
  input  logic          rst,
  rr_mux_reg_if.slave   bus
);
  localparam int SW = $clog2(CH);

  // Returns {found, index}: the first valid channel after `last`, wrapping mod CH.
  // Scanning from farthest to nearest lets the nearest valid channel win.
  function automatic logic [SW:0] rr_pick(input logic [CH-1:0] v, input logic [SW-1:0] last);
    logic [SW:0] r;
    int          c;
    r = '0;
    for (int k = CH; k >= 1; k--) begin
      c = (int'(last) + k) % CH;
      if (v[c]) r = {1'b1, SW'(c)};
    end
    return r;
  endfunction

  logic          vld_p0;
  logic [N-1:0]  data_p0;
  logic [SW-1:0] sel_p0;
  logic [SW-1:0] last_p0;

  logic [SW:0]   arb;
  logic          win;
  logic [SW-1:0] g;
  logic          ld;
  logic [CH-1:0] rdy;
  logic [N-1:0]  win_data;

  always_comb begin
    arb      = rst ? '0 : rr_pick(bus.in_valid, last_p0);
    win      = arb[SW];
    g        = arb[SW-1:0];
    ld       = !vld_p0 || bus.out_ready;
    rdy      = '0;
    win_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (g == SW'(i)) begin
        rdy[i]   = ld && win;
        win_data = bus.in_data[i*N +: N];
      end
    end
  end

  assign bus.in_ready = rdy;

  // p0: output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
      last_p0 <= SW'(CH - 1);
    end else if (ld && win) begin
      vld_p0  <= 1'b1;
      data_p0 <= win_data;
      sel_p0  <= g;
      last_p0 <= g;
    end else if (bus.out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p0;
  assign bus.out_data  = data_p0;
  assign bus.out_sel   = sel_p0;
endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: a CH=4 and a CH=3 instance, each tracked by a behavioural
// model compared every cycle, plus directed vectors with literal expectations.
module tb_rr_mux_reg;
  logic clk = 1'b0;
  logic rst4, rst3;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rr_mux_reg_if #(.N(32), .CH(4)) b4();
  rr_mux_reg_if #(.N(32), .CH(3)) b3();

  rr_mux_reg #(.N(32), .CH(4)) u4 (.clk(clk), .rst(rst4), .bus(b4));
  rr_mux_reg #(.N(32), .CH(3)) u3 (.clk(clk), .rst(rst3), .bus(b3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state per instance: index 0 is the CH=4 DUT, index 1 the CH=3 DUT.
  int          m_v[2];
  int          m_s[2];
  int          m_last[2];
  logic [31:0] m_d[2];

  // Winner = valid channel at the smallest forward distance past `last`.
  function automatic int mpick(input int ch, input int v, input int last);
    int best  = -1;
    int bestd = ch;
    for (int c = 0; c < ch; c++) begin
      if (v[c]) begin
        int d = (c - last - 1 + 2*ch) % ch;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  function automatic int exp_rdy(input int k, input int ch, input logic r, input int v, input logic o);
    int g;
    if (r) return 0;
    g = mpick(ch, v, m_last[k]);
    if (g >= 0 && (m_v[k] == 0 || o)) return 1 << g;
    return 0;
  endfunction

  task automatic step(input int k, input int ch, input logic r, input int v,
                      input logic [127:0] dat, input logic o);
    int g;
    if (r) begin
      m_v[k] = 0; m_d[k] = '0; m_s[k] = 0; m_last[k] = ch - 1;
    end else begin
      g = mpick(ch, v, m_last[k]);
      if ((m_v[k] == 0 || o) && g >= 0) begin
        m_v[k] = 1; m_d[k] = dat[g*32 +: 32]; m_s[k] = g; m_last[k] = g;
      end else if (m_v[k] != 0 && o) begin
        m_v[k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    step(0, 4, rst4, int'(b4.in_valid), b4.in_data, b4.out_ready);
    step(1, 3, rst3, int'(b3.in_valid), {32'b0, b3.in_data}, b3.out_ready);
  end

  always @(negedge clk) begin
    chk("m4 in_ready",  32'(b4.in_ready),
        32'(exp_rdy(0, 4, rst4, int'(b4.in_valid), b4.out_ready)));
    chk("m4 out_valid", 32'(b4.out_valid), 32'(m_v[0]));
    chk("m4 out_data",  b4.out_data, m_d[0]);
    chk("m4 out_sel",   32'(b4.out_sel), 32'(m_s[0]));
    chk("m3 in_ready",  32'(b3.in_ready),
        32'(exp_rdy(1, 3, rst3, int'(b3.in_valid), b3.out_ready)));
    chk("m3 out_valid", 32'(b3.out_valid), 32'(m_v[1]));
    chk("m3 out_data",  b3.out_data, m_d[1]);
    chk("m3 out_sel",   32'(b3.out_sel), 32'(m_s[1]));
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    b4.in_valid  = 4'b1111;
    b4.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    b4.out_ready = 1'b1;
    b3.in_valid  = 3'b000;
    b3.in_data   = '0;
    b3.out_ready = 1'b1;

    // Reset held for two edges with every channel requesting
    cyc(); cyc(); settle();
    chk("rst out_valid", 32'(b4.out_valid), 32'd0);
    chk("rst out_data",  b4.out_data, 32'd0);
    chk("rst in_ready",  32'(b4.in_ready), 32'b0000);
    rst4 = 1'b0;
    settle();
    chk("post-rst in_ready", 32'(b4.in_ready), 32'b0001);

    // Rotation with all channels valid, no bubbles
    for (int j = 0; j < 6; j++) begin
      cyc(); settle();
      chk("rot sel",   32'(b4.out_sel), 32'(j % 4));
      chk("rot data",  b4.out_data, 32'hA0 + 32'(j % 4));
      chk("rot valid", 32'(b4.out_valid), 32'd1);
    end

    // Backpressure while 0xA1 is held
    b4.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      settle();
      chk("bp data",     b4.out_data, 32'hA1);
      chk("bp in_ready", 32'(b4.in_ready), 32'b0000);
      cyc();
    end
    b4.out_ready = 1'b1;
    settle();
    chk("bp release in_ready", 32'(b4.in_ready), 32'b0100);
    cyc(); settle();
    chk("bp resume sel", 32'(b4.out_sel), 32'd2);
    cyc(); settle();
    chk("bp resume sel", 32'(b4.out_sel), 32'd3);

    // Sparse: channels 1 and 3 only, last = 3
    b4.in_valid = 4'b1010;
    settle();
    chk("sparse in_ready", 32'(b4.in_ready), 32'b0010);
    for (int j = 0; j < 4; j++) begin
      cyc(); settle();
      chk("sparse sel", 32'(b4.out_sel), (j % 2 == 1) ? 32'd3 : 32'd1);
    end
    b4.in_valid = 4'b0010;
    for (int j = 0; j < 3; j++) begin
      cyc(); settle();
      chk("single sel",   32'(b4.out_sel), 32'd1);
      chk("single valid", 32'(b4.out_valid), 32'd1);
    end

    // Drain to empty: one beat on channel 2
    b4.in_valid = 4'b0100;
    b4.in_data[64 +: 32] = 32'hDEAD;
    cyc(); settle();
    chk("drain sel",   32'(b4.out_sel), 32'd2);
    chk("drain data",  b4.out_data, 32'hDEAD);
    chk("drain valid", 32'(b4.out_valid), 32'd1);
    b4.in_valid = 4'b0000;
    for (int j = 0; j < 2; j++) begin
      cyc(); settle();
      chk("drained valid", 32'(b4.out_valid), 32'd0);
      chk("drained data",  b4.out_data, 32'hDEAD);
    end

    // Non-power-of-two channel count
    rst3 = 1'b0;
    b3.in_valid = 3'b111;
    b3.in_data  = {32'hB2, 32'hB1, 32'hB0};
    settle();
    chk("ch3 in_ready", 32'(b3.in_ready), 32'b001);
    for (int j = 0; j < 6; j++) begin
      cyc(); settle();
      chk("ch3 sel",  32'(b3.out_sel), 32'(j % 3));
      chk("ch3 data", b3.out_data, 32'hB0 + 32'(j % 3));
    end
    rst3 = 1'b1;
    settle();
    chk("ch3 rst in_ready", 32'(b3.in_ready), 32'b000);
    cyc(); settle();
    chk("ch3 rst valid", 32'(b3.out_valid), 32'd0);
    rst3 = 1'b0;
    cyc(); settle();
    chk("ch3 restart sel",   32'(b3.out_sel), 32'd0);
    chk("ch3 restart valid", 32'(b3.out_valid), 32'd1);
    cyc(); settle();
    chk("ch3 restart sel", 32'(b3.out_sel), 32'd1);

    cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
